// File: rtl/irq_ctl.sv
// irq_ctl: prioritized interrupt controller with mask/pend registers and an IDLE/REQ/SERV handshake FSM.
// Define IRQ_CTL_EDGE_EN for rising-edge pend capture; level-sensitive pend otherwise.
module irq_ctl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_irq,
  input  logic             iack,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic [7:0]       cfg_rdata,
  output logic             irq,
  output logic [2:0]       irq_vec
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2} state_t;
  state_t state;
  logic [N_SRC-1:0] mask, pend, req, pend_nx;
  logic [2:0] sel;
  logic iack_d, ack_rise, ack_fall;
  assign ack_rise = iack & ~iack_d;
  assign ack_fall = ~iack & iack_d;
  assign req = pend & mask;
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (req[i]) sel = 3'(i);
  end
`ifdef IRQ_CTL_EDGE_EN
  logic [N_SRC-1:0] src_d, clr;
  // set beats clear: the new edge is ORed in after the clear mask is applied
  always_comb begin
    clr = ((cfg_we && cfg_addr == 2'd1) ? cfg_wdata[N_SRC-1:0] : '0)
        | ((state == REQ && ack_rise) ? (N_SRC'(1) << irq_vec) : '0);
    pend_nx = (pend & ~clr) | (src_irq & ~src_d);
  end
  always_ff @(posedge clk) src_d <= rst ? '0 : src_irq;
`else
  assign pend_nx = src_irq;
`endif
  always_comb
    cfg_rdata = cfg_addr == 2'd0 ? 8'(mask)
              : cfg_addr == 2'd1 ? 8'(pend)
              : cfg_addr == 2'd2 ? {4'b0, state == SERV, irq_vec}
              : 8'h00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      irq     <= 1'b0;
      irq_vec <= '0;
      mask    <= '0;
      pend    <= '0;
      iack_d  <= 1'b0;
    end else begin
      iack_d <= iack;
      pend   <= pend_nx;
      if (cfg_we && cfg_addr == 2'd0) mask <= cfg_wdata[N_SRC-1:0];
      case (state)
        IDLE: if (|req) begin
          state   <= REQ;
          irq     <= 1'b1;
          irq_vec <= sel;
        end
        REQ: if (ack_rise) begin
          state <= SERV;
          irq   <= 1'b0;
        end
        SERV: if (ack_fall) state <= IDLE;
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: directed self-checking bench for irq_ctl; edge-capture scenarios run when IRQ_CTL_EDGE_EN is defined.
module tb_irq_ctl;
  logic clk = 1'b0, rst = 1'b1, iack = 1'b0, cfg_we = 1'b0;
  logic [7:0] src_irq = '0, cfg_wdata = '0, cfg_rdata;
  logic [1:0] cfg_addr = '0;
  logic irq;
  logic [2:0] irq_vec;
  int checks = 0, errors = 0;

  irq_ctl #(.N_SRC(8)) dut (
    .clk(clk), .rst(rst), .src_irq(src_irq), .iack(iack), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irq(irq), .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a);
    cfg_addr = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0h exp 0", irq); end
    checks++; if (irq_vec !== 3'd0) begin errors++; $display("FAIL reset_vec got %0h exp 0", irq_vec); end
    rd(0); checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL reset_mask got %0h exp 00", cfg_rdata); end
    rd(1); checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL reset_pend got %0h exp 00", cfg_rdata); end
    rd(2); checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL reset_status got %0h exp 00", cfg_rdata); end
  endtask

  task automatic test_basic;
    wr(0, 8'h05);
    rd(0); checks++; if (cfg_rdata !== 8'h05) begin errors++; $display("FAIL basic_mask got %0h exp 05", cfg_rdata); end
    src_irq = 8'h04;
    tick();
`ifdef IRQ_CTL_EDGE_EN
    src_irq = 8'h00;
`endif
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_latency_early got %0h exp 0", irq); end
    rd(1); checks++; if (cfg_rdata !== 8'h04) begin errors++; $display("FAIL basic_pend got %0h exp 04", cfg_rdata); end
    tick();
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd2) begin errors++; $display("FAIL basic_grant got irq=%0h vec=%0d exp irq=1 vec=2", irq, irq_vec); end
    src_irq = 8'h00;
    iack = 1'b1;
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_ack_irq got %0h exp 0", irq); end
    rd(1); checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL basic_ack_pend got %0h exp 00", cfg_rdata); end
    rd(2); checks++; if (cfg_rdata !== 8'h0A) begin errors++; $display("FAIL basic_status_serv got %0h exp 0a", cfg_rdata); end
    iack = 1'b0;
    tick();
    rd(2); checks++; if (cfg_rdata[3] !== 1'b0) begin errors++; $display("FAIL basic_serv_exit got %0h exp 0", cfg_rdata[3]); end
  endtask

  task automatic test_masked;
    src_irq = 8'h02;
    tick(3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked_src_irq got %0h exp 0", irq); end
    src_irq = 8'h00;
    wr(1, 8'hFF);
    tick();
  endtask

  task automatic test_priority;
    wr(0, 8'hFF);
    src_irq = 8'h42;
    tick();
`ifdef IRQ_CTL_EDGE_EN
    src_irq = 8'h00;
`endif
    tick();
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd1) begin errors++; $display("FAIL prio_first got irq=%0h vec=%0d exp irq=1 vec=1", irq, irq_vec); end
`ifndef IRQ_CTL_EDGE_EN
    src_irq = 8'h40;
`endif
    iack = 1'b1;
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_ack got %0h exp 0", irq); end
    iack = 1'b0;
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_idle_gap got %0h exp 0", irq); end
    tick();
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd6) begin errors++; $display("FAIL prio_second got irq=%0h vec=%0d exp irq=1 vec=6", irq, irq_vec); end
    src_irq = 8'h00;
    iack = 1'b1;
    tick();
    iack = 1'b0;
    tick(2);
  endtask

  task automatic test_mask_hold;
    src_irq = 8'h08;
    tick();
`ifdef IRQ_CTL_EDGE_EN
    src_irq = 8'h00;
`endif
    tick();
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd3) begin errors++; $display("FAIL hold_grant got irq=%0h vec=%0d exp irq=1 vec=3", irq, irq_vec); end
    wr(0, 8'h00);
    tick(2);
    rd(0); checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL hold_mask got %0h exp 00", cfg_rdata); end
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd3) begin errors++; $display("FAIL hold_stable got irq=%0h vec=%0d exp irq=1 vec=3", irq, irq_vec); end
    src_irq = 8'h00;
    iack = 1'b1;
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL hold_ack got %0h exp 0", irq); end
    iack = 1'b0;
    tick(2);
  endtask

  task automatic test_iack_ignore;
    src_irq = 8'h01;
    tick();
`ifdef IRQ_CTL_EDGE_EN
    src_irq = 8'h00;
`endif
    iack = 1'b1;
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ignore_irq got %0h exp 0", irq); end
    rd(1); checks++; if (cfg_rdata !== 8'h01) begin errors++; $display("FAIL ignore_pend got %0h exp 01", cfg_rdata); end
    rd(2); checks++; if (cfg_rdata[3] !== 1'b0) begin errors++; $display("FAIL ignore_state got %0h exp 0", cfg_rdata[3]); end
    iack = 1'b0;
    tick();
  endtask

`ifdef IRQ_CTL_EDGE_EN
  task automatic test_w1c_race;
    wr(1, 8'hFF);
    src_irq = 8'h10;
    tick();
    src_irq = 8'h00;
    tick();
    rd(1); checks++; if (cfg_rdata !== 8'h10) begin errors++; $display("FAIL race_pre got %0h exp 10", cfg_rdata); end
    src_irq = 8'h10;
    wr(1, 8'h10);
    rd(1); checks++; if (cfg_rdata !== 8'h10) begin errors++; $display("FAIL race_set_wins got %0h exp 10", cfg_rdata); end
    wr(1, 8'h10);
    rd(1); checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL race_w1c got %0h exp 00", cfg_rdata); end
    src_irq = 8'h00;
    tick();
  endtask

  task automatic test_enter_serv;
    wr(0, 8'h01);
    src_irq = 8'h01;
    tick();
    src_irq = 8'h00;
    tick();
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd0) begin errors++; $display("FAIL edge_grant got irq=%0h vec=%0d exp irq=1 vec=0", irq, irq_vec); end
  endtask
`else
  task automatic test_level_rearm;
    src_irq = 8'h01;
    wr(0, 8'h01);
    wr(1, 8'h01);
    rd(1); checks++; if (cfg_rdata !== 8'h01) begin errors++; $display("FAIL level_w1c got %0h exp 01", cfg_rdata); end
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd0) begin errors++; $display("FAIL level_grant got irq=%0h vec=%0d exp irq=1 vec=0", irq, irq_vec); end
    iack = 1'b1;
    tick();
    iack = 1'b0;
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL level_idle_gap got %0h exp 0", irq); end
    tick();
    checks++; if (irq !== 1'b1 || irq_vec !== 3'd0) begin errors++; $display("FAIL level_rearm got irq=%0h vec=%0d exp irq=1 vec=0", irq, irq_vec); end
  endtask
`endif

  task automatic test_reset_mid;
    iack = 1'b1;
    tick(2);
    rd(2); checks++; if (cfg_rdata !== 8'h08) begin errors++; $display("FAIL mid_in_serv got %0h exp 08", cfg_rdata); end
    rst = 1'b1;
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq got %0h exp 0", irq); end
    rd(2); checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL mid_rst_status got %0h exp 00", cfg_rdata); end
    rd(0); checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL mid_rst_mask got %0h exp 00", cfg_rdata); end
    rd(1); checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL mid_rst_pend got %0h exp 00", cfg_rdata); end
    src_irq = 8'h00;
    iack = 1'b0;
    rst = 1'b0;
    tick(3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_release_irq got %0h exp 0", irq); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_masked();
    test_priority();
    test_mask_hold();
    test_iack_ignore();
`ifdef IRQ_CTL_EDGE_EN
    test_w1c_race();
    test_enter_serv();
`else
    test_level_rearm();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_ctl.md
IRQ_CTL -- requirements
Module: irq_ctl

Interface
REQ-001 SHALL have parameter N_SRC, default 8, number of interrupt sources; legal range 2..8.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port src_irq, input, N_SRC, raw interrupt sources, synchronous to clk; bit 0 is highest priority.
REQ-005 SHALL have port iack, input, 1, acknowledge level from the pipeline control FSM; high while the handler is in service.
REQ-006 SHALL have ports cfg_we (input, 1), cfg_addr (input, 2) and cfg_wdata (input, 8), the register write strobe, address and data.
REQ-007 SHALL have port cfg_rdata, output, 8, the combinational read data for cfg_addr.
REQ-008 SHALL have port irq, output, 1, registered interrupt request to the control FSM.
REQ-009 SHALL have port irq_vec, output, 3, registered index of the granted source, valid while irq or in service.

Function
REQ-010 SHALL implement states IDLE, REQ and SERV, encoded in 2 bits; the unused code SHALL go to IDLE.
REQ-011 In IDLE, if (pend & mask) is nonzero, SHALL go to REQ next cycle, set irq=1 and latch irq_vec to the lowest set index.
REQ-012 In REQ, SHALL hold irq=1 and irq_vec stable regardless of mask or pend changes; there is no withdrawal.
REQ-013 In REQ, on an iack rise (iack=1 and the registered iack_d=0), SHALL clear pend[irq_vec], set irq=0 and go to SERV in the same cycle.
REQ-014 In SERV, SHALL hold irq=0 and irq_vec; on an iack fall (iack=0 and iack_d=1), SHALL go to IDLE.
REQ-015 Re-arbitration SHALL occur only in IDLE, so there is at least 1 idle cycle between SERV exit and the next irq.
REQ-016 Register map, cfg_addr:
 - 0 = mask, RW; a 1 enables the source.
 - 1 = pend, read; a write-1 clears the bit.
 - 2 = status {4'b0, in_serv, irq_vec}, RO.
 - 3 = reads 0, writes ignored.
REQ-017 Bits at or above N_SRC in mask and pend SHALL read 0 and ignore writes.
REQ-018 When a pend set event and a clear event (W1C or acknowledge) hit the same bit in the same cycle, set SHALL win.
REQ-019 A mask write SHALL take effect for arbitration in the cycle after the write.
REQ-020 An iack rise seen in IDLE or SERV SHALL be ignored; pend and state SHALL be unchanged.
REQ-021 Latency SHALL be exactly 1 cycle from pend&mask nonzero in IDLE to irq=1.

Reset
REQ-022 While rst=1, SHALL clear state to IDLE and set irq=0, irq_vec=0, mask=0, pend=0, iack_d=0 and src_d=0.
REQ-023 An rst asserted mid-REQ or mid-SERV SHALL abandon the transaction and clear pend, without emitting a spurious irq on release.

Configuration
REQ-024 The macro IRQ_CTL_EDGE_EN SHALL select edge capture: pend[i] is set on a src_irq[i] 0->1 transition (src_d[i]=0, src_irq[i]=1), independent of mask.
REQ-025 Without IRQ_CTL_EDGE_EN, pend SHALL be level-sensitive:
 - pend[i] = src_irq[i] each cycle.
 - W1C and acknowledge clears have no lasting effect.
 - The source must deassert before iack falls, else it is re-requested.

Verification
REQ-026 Reset, then mask=0x05, pulse src_irq[2] -> irq=1 two cycles after the edge (one cycle edge-to-pend, per REQ-024, plus REQ-021), irq_vec=2; iack rise -> irq=0, pend=0x00.
REQ-027 src_irq[1] and src_irq[6] rise the same cycle, mask=0xFF -> grant vec=1; after the iack fall plus 1 idle cycle -> grant vec=6.
REQ-028 In REQ with vec=3, write mask=0x00 -> irq stays 1 and vec stays 3 until the iack rise.
REQ-029 W1C of pend[4] in the same cycle as a src_irq[4] rising edge (EDGE_EN) -> pend[4] reads 1 the next cycle.
REQ-030 rst asserted 1 cycle into SERV -> next cycle state=IDLE, irq=0, status=0x00, mask=0x00.
REQ-031 Build without IRQ_CTL_EDGE_EN, hold src_irq[0]=1 through an iack rise and fall -> irq re-asserts with vec=0 after 1 idle cycle.
